costas_loop_filter: RTL
=======================

COSTAS_LOOP_FILTER -- requirements
Module: costas_loop_filter

Interface
REQ-001 The block SHALL expose these parameters:
  KP_ACQ  4  proportional right-shift, ACQUIRE
  KI_ACQ  10  integral right-shift, ACQUIRE
  KP_TRK  6  proportional right-shift, TRACK
  KI_TRK  14  integral right-shift, TRACK
  LOCK_THR  32'h0010_0000  |pd| lock threshold
  LOCK_COUNT  64  consecutive in-threshold samples to declare lock
  UNLOCK_COUNT  16  consecutive out-of-threshold samples to drop lock
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL expose these ports:
  clk  in  1  clock, rising edge
  reset  in  1  asynchronous active-high reset
  i_in  in  16  signed I-arm mixer output
  q_in  in  16  signed Q-arm mixer output
  in_valid  in  1  i_in/q_in sample strobe
  clear  in  1  synchronous integrator/state clear
  error  out  32  signed loop correction to NCO frequency input
  err_valid  out  1  error updated this cycle
  locked  out  1  high in TRACK state

Function
REQ-004 Stage 1: on in_valid, register pd = i_in*q_in (signed 32-bit product; -32768*-32768 = 0x4000_0000 fits) and a valid flag.
REQ-005 Stage 2: on stage-1 valid, integ <= sat32(integ + (pd >>> KI)); error <= sat32(integ_new + (pd >>> KP)), with KP/KI taken from the current state.
REQ-006 Shifts SHALL be arithmetic (sign-preserving, floor); sums SHALL be formed in 33 bits; sat32 clamps to 0x7FFF_FFFF / 0x8000_0000.
REQ-007 err_valid SHALL pulse high for one cycle exactly 2 cycles after the in_valid cycle; error SHALL hold its value between pulses.
REQ-008 Back-to-back in_valid SHALL be accepted every cycle with no bubbles.
REQ-009 The FSM SHALL have states ACQUIRE (locked=0) and TRACK (locked=1) and a saturating run counter updated on each stage-2 valid.
REQ-010 In ACQUIRE: |pd| < LOCK_THR increments the counter, otherwise the counter clears; counter reaching LOCK_COUNT moves to TRACK and clears the counter.
REQ-011 In TRACK: |pd| >= LOCK_THR increments the counter, otherwise the counter clears; counter reaching UNLOCK_COUNT moves to ACQUIRE and clears the counter.
REQ-012 |pd| SHALL be computed in 33 bits so that |0x8000_0000| is not misclassified.
REQ-013 The gain change SHALL take effect on the first sample after the transition cycle, not the transition sample itself.
REQ-014 On clear: integ, counter and error SHALL go to 0, state SHALL go to ACQUIRE, and pipeline valids SHALL be dropped in that cycle; clear SHALL win over a simultaneous in_valid or stage-2 valid.

Reset
REQ-015 On reset assertion, asynchronously: error=0, err_valid=0, locked=0, integ=0, counter=0, pd register=0, valids=0, state=ACQUIRE.
REQ-016 Reset mid-stream SHALL discard in-flight samples; the first err_valid after release SHALL come 2 cycles after the first post-release in_valid.

Structure
REQ-017 Package costas_pkg SHALL hold the data widths, the SAT_MAX/SAT_MIN constants and the ACQUIRE/TRACK state encoding, shared with the NCO and mixers.
REQ-018 Stage 1 SHALL be a sub-module costas_pd (registered multiplier with valid); saturation and PI logic SHALL stay in the top level.

Verification
REQ-019 Reset, then i_in=q_in=16384 with one in_valid -> err_valid 2 cycles later, error=0x0104_0000; a second identical sample -> error=0x0108_0000.
REQ-020 Continuous i_in=q_in=-32768 -> integ clamps at 0x7FFF_FFFF on sample 2048, error stays 0x7FFF_FFFF with no wrap; negated q_in -> clamp at 0x8000_0000.
REQ-021 i_in=q_in=0 for 64 samples -> locked rises after sample 64; then i_in=q_in=16384 for 16 samples -> locked falls after sample 16; 15 bad samples followed by 1 good sample -> locked stays 1.
REQ-022 Assert clear on the same cycle as in_valid with the integrator nonzero -> integ=0, error=0, no err_valid for that sample, locked=0.
REQ-023 Assert reset asynchronously between clock edges during a burst -> all outputs 0 immediately; after release the first err_valid comes exactly 2 cycles after the first in_valid.
REQ-024 Drive in_valid every cycle for 100 cycles -> 100 err_valid pulses, each exactly 2 cycles after its sample.

Source files
------------

// File: rtl/costas_pkg.sv
// Shared Costas-loop definitions: data widths, saturation limits and loop state
// encoding used by the loop filter, NCO and mixers.
package costas_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 33;

  localparam logic [PROD_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [PROD_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } loop_state_t;

  // Clamp a 33-bit two's-complement sum into the signed 32-bit range
  function automatic logic [PROD_W-1:0] sat32(input logic [ACC_W-1:0] x);
    logic [PROD_W-1:0] r;
    if (x[ACC_W-1] != x[ACC_W-2]) begin
      if (x[ACC_W-1]) begin
        r = SAT_MIN;
      end else begin
        r = SAT_MAX;
      end
    end else begin
      r = x[PROD_W-1:0];
    end
    return r;
  endfunction

  // Magnitude in 33 bits so that the most negative product stays positive
  function automatic logic [ACC_W-1:0] abs33(input logic [PROD_W-1:0] x);
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] r;
    ext = {x[PROD_W-1], x};
    if (x[PROD_W-1]) begin
      r = ~ext + 33'd1;
    end else begin
      r = ext;
    end
    return r;
  endfunction

endpackage

// File: rtl/costas_pd.sv
// Costas phase detector: registered signed I*Q product with a sample-valid flag.
module costas_pd
  import costas_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] q_in,
  input  logic              in_valid,
  output logic [PROD_W-1:0] pd,
  output logic              pd_valid
);

  logic signed [PROD_W-1:0] i_ext_s;
  logic signed [PROD_W-1:0] q_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic        [PROD_W-1:0] pd_r;
  logic                     pd_valid_r;

  assign i_ext_s = {{(PROD_W-DATA_W){i_in[DATA_W-1]}}, i_in};
  assign q_ext_s = {{(PROD_W-DATA_W){q_in[DATA_W-1]}}, q_in};
  assign prod_s  = i_ext_s * q_ext_s;

  // Product register; clear drops any sample presented in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pd_r       <= {PROD_W{1'b0}};
      pd_valid_r <= 1'b0;
    end else if (clear) begin
      pd_r       <= {PROD_W{1'b0}};
      pd_valid_r <= 1'b0;
    end else begin
      pd_valid_r <= in_valid;
      if (in_valid) begin
        pd_r <= prod_s;
      end else begin
        pd_r <= pd_r;
      end
    end
  end

  assign pd       = pd_r;
  assign pd_valid = pd_valid_r;

endmodule

// File: rtl/costas_loop_filter.sv
// Costas loop PI filter: phase-detector stage, saturating integrator and
// proportional path, with an ACQUIRE/TRACK lock FSM selecting the gains.
module costas_loop_filter
  import costas_pkg::*;
#(
  parameter int          KP_ACQ       = 4,
  parameter int          KI_ACQ       = 10,
  parameter int          KP_TRK       = 6,
  parameter int          KI_TRK       = 14,
  parameter logic [31:0] LOCK_THR     = 32'h0010_0000,
  parameter int          LOCK_COUNT   = 64,
  parameter int          UNLOCK_COUNT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_in,
  input  logic [15:0] q_in,
  input  logic        in_valid,
  input  logic        clear,
  output logic [31:0] error,
  output logic        err_valid,
  output logic        locked
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_CNT_C   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_CNT_C = CNT_W'(UNLOCK_COUNT);

  logic [PROD_W-1:0]        pd_s;
  logic                     pd_v_s;
  logic signed [ACC_W-1:0]  pd_ext_s;
  logic signed [ACC_W-1:0]  ki_term_s;
  logic signed [ACC_W-1:0]  kp_term_s;
  logic [ACC_W-1:0]         sum_i_s;
  logic [ACC_W-1:0]         sum_e_s;
  logic [PROD_W-1:0]        integ_new_s;
  logic [PROD_W-1:0]        error_new_s;
  int                       kp_s;
  int                       ki_s;
  logic                     in_thr_s;
  logic [CNT_W-1:0]         cnt_inc_s;
  logic [CNT_W-1:0]         cnt_next_s;
  loop_state_t              state_next_s;

  logic [PROD_W-1:0]        integ_r;
  logic [PROD_W-1:0]        error_r;
  logic                     err_valid_r;
  logic [CNT_W-1:0]         cnt_r;
  loop_state_t              state_r;
  logic                     locked_r;

  costas_pd u_pd (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .i_in     (i_in),
    .q_in     (q_in),
    .in_valid (in_valid),
    .pd       (pd_s),
    .pd_valid (pd_v_s)
  );

  // PI arithmetic; gains come from the registered state, so the sample that
  // causes a transition is still filtered with the old gains
  always_comb begin
    kp_s = KP_ACQ;
    ki_s = KI_ACQ;
    if (state_r == TRACK) begin
      kp_s = KP_TRK;
      ki_s = KI_TRK;
    end else begin
      kp_s = KP_ACQ;
      ki_s = KI_ACQ;
    end
    pd_ext_s    = {pd_s[PROD_W-1], pd_s};
    ki_term_s   = pd_ext_s >>> ki_s;
    kp_term_s   = pd_ext_s >>> kp_s;
    sum_i_s     = {integ_r[PROD_W-1], integ_r} + ki_term_s;
    integ_new_s = sat32(sum_i_s);
    sum_e_s     = {integ_new_s[PROD_W-1], integ_new_s} + kp_term_s;
    error_new_s = sat32(sum_e_s);
  end

  // Lock FSM next state and run counter
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    in_thr_s     = (abs33(pd_s) < {1'b0, LOCK_THR});
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
    if (pd_v_s) begin
      case (state_r)
        ACQUIRE: begin
          if (!in_thr_s) begin
            cnt_next_s = {CNT_W{1'b0}};
          end else if (cnt_inc_s == LOCK_CNT_C) begin
            state_next_s = TRACK;
            cnt_next_s   = {CNT_W{1'b0}};
          end else begin
            cnt_next_s = cnt_inc_s;
          end
        end
        TRACK: begin
          if (in_thr_s) begin
            cnt_next_s = {CNT_W{1'b0}};
          end else if (cnt_inc_s == UNLOCK_CNT_C) begin
            state_next_s = ACQUIRE;
            cnt_next_s   = {CNT_W{1'b0}};
          end else begin
            cnt_next_s = cnt_inc_s;
          end
        end
        default: begin
          state_next_s = ACQUIRE;
          cnt_next_s   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
    end
  end

  // Lock FSM state, counter and lock indicator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ACQUIRE;
      cnt_r    <= {CNT_W{1'b0}};
      locked_r <= 1'b0;
    end else if (clear) begin
      state_r  <= ACQUIRE;
      cnt_r    <= {CNT_W{1'b0}};
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      locked_r <= (state_next_s == TRACK);
    end
  end

  // Integrator and error output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      integ_r     <= {PROD_W{1'b0}};
      error_r     <= {PROD_W{1'b0}};
      err_valid_r <= 1'b0;
    end else if (clear) begin
      integ_r     <= {PROD_W{1'b0}};
      error_r     <= {PROD_W{1'b0}};
      err_valid_r <= 1'b0;
    end else begin
      err_valid_r <= pd_v_s;
      if (pd_v_s) begin
        integ_r <= integ_new_s;
        error_r <= error_new_s;
      end else begin
        integ_r <= integ_r;
        error_r <= error_r;
      end
    end
  end

  assign error     = error_r;
  assign err_valid = err_valid_r;
  assign locked    = locked_r;

endmodule
